// File: rtl/beat_clock_gen.sv
`default_nettype none
// ============================================================================
// beat_clock_gen : phase-coherent metronome (tick / beat / measure) whose tick
//                  period comes from an on-chip restoring divider
// Rev 1.0
// ============================================================================
module beat_clock_gen #(
   parameter int unsigned CLK_HZ            = 200_000_000,
   parameter int unsigned SUBDIV            = 4,
   parameter int unsigned BEATS_PER_MEASURE = 4
) (
   input  logic        clk_camera_in,
   input  logic        rst_in,
   input  logic        enable_in,
   input  logic [7:0]  bpm_in,
   input  logic        sync_in,
   output logic        tick_out,
   output logic        beat_out,
   output logic        measure_out,
   output logic [3:0]  sub_idx_out,
   output logic [3:0]  beat_idx_out,
   output logic [31:0] period_out,
   output logic        running_out
);

   localparam logic [63:0]          c_DIVIDEND  = 64'(CLK_HZ) * 64'd60;
   localparam int                   c_DVD_W     = $clog2(c_DIVIDEND + 64'd1);
   localparam int                   c_CNT_W     = $clog2(c_DVD_W + 1);
   localparam logic [c_CNT_W-1:0]   c_CNT_LAST  = c_CNT_W'(c_DVD_W - 1);
   localparam logic [c_DVD_W-1:0]   c_DVD_INIT  = c_DIVIDEND[c_DVD_W-1:0];
   localparam logic [3:0]           c_SUB_LAST  = 4'(SUBDIV - 1);
   localparam logic [3:0]           c_BEAT_LAST = 4'(BEATS_PER_MEASURE - 1);
   localparam logic [11:0]          c_SUBDIV    = 12'(SUBDIV);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DIVIDE = 2'd1,
      S_RUN    = 2'd2
   } state_t;

   state_t               r_state,    w_state_nxt;
   logic [7:0]           r_bpm_lat,  w_bpm_lat_nxt;
   logic                 r_div_busy, w_busy_nxt;
   logic [c_CNT_W-1:0]   r_div_cnt,  w_cnt_nxt;
   logic [c_DVD_W-1:0]   r_dvd,      w_dvd_nxt;
   logic [11:0]          r_rem,      w_rem_nxt;
   logic [11:0]          r_divisor,  w_divisor_nxt;
   logic                 r_stale,    w_stale_nxt;
   logic                 r_restart,  w_restart_nxt;
   logic                 r_pend_vld, w_pend_vld_nxt;
   logic [31:0]          r_pend,     w_pend_nxt;
   logic [31:0]          r_period,   w_period_nxt;
   logic [31:0]          r_phase,    w_phase_nxt;
   logic [3:0]           r_sub,      w_sub_nxt;
   logic [3:0]           r_beat,     w_beat_nxt;

   logic                 w_start;
   logic                 w_clear;
   logic                 w_boundary;
   logic                 w_stop;
   logic [12:0]          w_rem_sh;
   logic                 w_qbit;
   logic [11:0]          w_rem_step;
   logic [c_DVD_W-1:0]   w_quo;
   logic [31:0]          w_quo32;
   logic [31:0]          w_div_result;
   logic                 w_div_done;

   // Dividend bits shift out of the top of r_dvd while quotient bits shift in
   // at the bottom, so after c_DVD_W steps r_dvd holds the quotient.
   assign w_rem_sh   = {r_rem, r_dvd[c_DVD_W-1]};
   assign w_qbit     = (w_rem_sh >= {1'b0, r_divisor});
   assign w_rem_step = w_qbit ? 12'(w_rem_sh - {1'b0, r_divisor}) : w_rem_sh[11:0];
   assign w_quo      = {r_dvd[c_DVD_W-2:0], w_qbit};
   assign w_div_done = r_div_busy && (r_div_cnt == c_CNT_LAST);

   generate
      if (c_DVD_W > 32) begin : g_sat
         assign w_quo32 = (|w_quo[c_DVD_W-1:32]) ? 32'hFFFF_FFFF : w_quo[31:0];
      end else begin : g_ext
         assign w_quo32 = 32'(w_quo);
      end
   endgenerate

   assign w_div_result = (w_quo32 == 32'd0) ? 32'd1 : w_quo32;
   assign w_stop       = !enable_in || (bpm_in == 8'd0);

   always_ff @(posedge clk_camera_in or negedge rst_in) begin
      if (!rst_in) begin
         r_state    <= S_IDLE;
         r_bpm_lat  <= '0;
         r_div_busy <= 1'b0;
         r_div_cnt  <= '0;
         r_dvd      <= '0;
         r_rem      <= '0;
         r_divisor  <= '0;
         r_stale    <= 1'b0;
         r_restart  <= 1'b0;
         r_pend_vld <= 1'b0;
         r_pend     <= '0;
         r_period   <= '0;
         r_phase    <= '0;
         r_sub      <= '0;
         r_beat     <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_bpm_lat  <= w_bpm_lat_nxt;
         r_div_busy <= w_busy_nxt;
         r_div_cnt  <= w_cnt_nxt;
         r_dvd      <= w_dvd_nxt;
         r_rem      <= w_rem_nxt;
         r_divisor  <= w_divisor_nxt;
         r_stale    <= w_stale_nxt;
         r_restart  <= w_restart_nxt;
         r_pend_vld <= w_pend_vld_nxt;
         r_pend     <= w_pend_nxt;
         r_period   <= w_period_nxt;
         r_phase    <= w_phase_nxt;
         r_sub      <= w_sub_nxt;
         r_beat     <= w_beat_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_bpm_lat_nxt  = r_bpm_lat;
      w_busy_nxt     = r_div_busy;
      w_cnt_nxt      = r_div_cnt;
      w_dvd_nxt      = r_dvd;
      w_rem_nxt      = r_rem;
      w_divisor_nxt  = r_divisor;
      w_stale_nxt    = r_stale;
      w_restart_nxt  = r_restart;
      w_pend_vld_nxt = r_pend_vld;
      w_pend_nxt     = r_pend;
      w_period_nxt   = r_period;
      w_phase_nxt    = r_phase;
      w_sub_nxt      = r_sub;
      w_beat_nxt     = r_beat;
      w_start        = 1'b0;
      w_clear        = 1'b0;
      w_boundary     = 1'b0;

      if (r_div_busy) begin
         w_rem_nxt = w_rem_step;
         w_dvd_nxt = w_quo;
         w_cnt_nxt = r_div_cnt + 1'b1;
         if (w_div_done) begin
            w_busy_nxt = 1'b0;
         end
      end

      case (r_state)
         S_IDLE: begin
            if (enable_in && (bpm_in != 8'd0)) begin
               w_state_nxt = S_DIVIDE;
               w_start     = 1'b1;
            end
         end
         S_DIVIDE: begin
            if (w_stop) begin
               w_clear = 1'b1;
            end else if (w_div_done) begin
               w_state_nxt  = S_RUN;
               w_period_nxt = w_div_result;
            end
         end
         S_RUN: begin
            if (w_stop) begin
               w_clear = 1'b1;
            end else begin
               if (sync_in) begin
                  w_phase_nxt = '0;
                  w_sub_nxt   = '0;
                  w_beat_nxt  = '0;
                  w_boundary  = 1'b1;
               end else if (r_phase == r_period - 32'd1) begin
                  w_phase_nxt = '0;
                  if (r_sub == c_SUB_LAST) begin
                     w_sub_nxt  = '0;
                     w_boundary = 1'b1;
                     w_beat_nxt = (r_beat == c_BEAT_LAST) ? 4'd0 : r_beat + 4'd1;
                  end else begin
                     w_sub_nxt = r_sub + 4'd1;
                  end
               end else begin
                  w_phase_nxt = r_phase + 32'd1;
               end

               // Apply before capturing a fresh result so a divide finishing on
               // the boundary edge waits for the following beat.
               if (w_boundary && r_pend_vld) begin
                  w_period_nxt   = r_pend;
                  w_pend_vld_nxt = 1'b0;
               end

               if (w_div_done) begin
                  if (r_stale || (bpm_in != r_bpm_lat)) begin
                     w_restart_nxt = 1'b1;
                  end else begin
                     w_pend_nxt     = w_div_result;
                     w_pend_vld_nxt = 1'b1;
                  end
                  w_stale_nxt = 1'b0;
               end else if (r_div_busy) begin
                  if (bpm_in != r_bpm_lat) begin
                     w_stale_nxt = 1'b1;
                  end
               end else if (r_restart || (bpm_in != r_bpm_lat)) begin
                  w_start       = 1'b1;
                  w_restart_nxt = 1'b0;
               end
            end
         end
         default: begin
            w_clear = 1'b1;
         end
      endcase

      if (w_start) begin
         w_bpm_lat_nxt = bpm_in;
         w_divisor_nxt = 12'(bpm_in) * c_SUBDIV;
         w_busy_nxt    = 1'b1;
         w_cnt_nxt     = '0;
         w_rem_nxt     = '0;
         w_dvd_nxt     = c_DVD_INIT;
      end

      if (w_clear) begin
         w_state_nxt    = S_IDLE;
         w_bpm_lat_nxt  = '0;
         w_busy_nxt     = 1'b0;
         w_cnt_nxt      = '0;
         w_dvd_nxt      = '0;
         w_rem_nxt      = '0;
         w_divisor_nxt  = '0;
         w_stale_nxt    = 1'b0;
         w_restart_nxt  = 1'b0;
         w_pend_vld_nxt = 1'b0;
         w_pend_nxt     = '0;
         w_period_nxt   = '0;
         w_phase_nxt    = '0;
         w_sub_nxt      = '0;
         w_beat_nxt     = '0;
      end
   end

   assign running_out  = (r_state == S_RUN);
   assign tick_out     = running_out && (r_phase == 32'd0);
   assign beat_out     = tick_out && (r_sub == 4'd0);
   assign measure_out  = beat_out && (r_beat == 4'd0);
   assign sub_idx_out  = r_sub;
   assign beat_idx_out = r_beat;
   assign period_out   = r_period;

endmodule
`default_nettype wire

// File: tb/tb_beat_clock_gen.sv
`default_nettype none
// ============================================================================
// tb_beat_clock_gen : directed + randomized bench for beat_clock_gen
// Rev 1.0
// ============================================================================
module tb_beat_clock_gen;

   localparam int CLK  = 1000;
   localparam int SUB  = 4;
   localparam int BPMS = 4;
   localparam int DW   = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        sync = 1'b0;
   logic [7:0]  bpm = 8'd0;
   logic        tick, beat, meas, run;
   logic [3:0]  sidx, bidx;
   logic [31:0] per;

   logic        en_f = 1'b0;
   logic [7:0]  bpm_f = 8'd0;
   logic        sync_f = 1'b0;
   logic        tick_f, beat_f, meas_f, run_f;
   logic [3:0]  sidx_f, bidx_f;
   logic [31:0] per_f;

   always #5 clk = ~clk;

   beat_clock_gen #(.CLK_HZ(CLK), .SUBDIV(SUB), .BEATS_PER_MEASURE(BPMS)) u_dut (
      .clk_camera_in(clk), .rst_in(rst), .enable_in(en), .bpm_in(bpm), .sync_in(sync),
      .tick_out(tick), .beat_out(beat), .measure_out(meas), .sub_idx_out(sidx),
      .beat_idx_out(bidx), .period_out(per), .running_out(run)
   );

   beat_clock_gen #(.CLK_HZ(4), .SUBDIV(2), .BEATS_PER_MEASURE(2)) u_fast (
      .clk_camera_in(clk), .rst_in(rst), .enable_in(en_f), .bpm_in(bpm_f), .sync_in(sync_f),
      .tick_out(tick_f), .beat_out(beat_f), .measure_out(meas_f), .sub_idx_out(sidx_f),
      .beat_idx_out(bidx_f), .period_out(per_f), .running_out(run_f)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: mode, ticks since downbeat, cycles since last tick.
   int m_mode, m_left, m_lat, m_period, m_since, m_cnt;
   int m_bg, m_bg_left, m_stale, m_restart, m_pv, m_pend;

   function automatic int calc(input int b);
      int q;
      q = (CLK * 60) / (b * SUB);
      return (q < 1) ? 1 : q;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_mode = 0; m_left = 0; m_lat = 0; m_period = 0; m_since = 0; m_cnt = 0;
      m_bg = 0; m_bg_left = 0; m_stale = 0; m_restart = 0; m_pv = 0; m_pend = 0;
   endtask

   task automatic model_step();
      int apply;
      if (m_mode == 0) begin
         if (en && bpm != 0) begin
            m_mode = 1; m_left = DW; m_lat = int'(bpm);
         end
      end else if (!en || bpm == 0) begin
         model_clear();
      end else if (m_mode == 1) begin
         m_left--;
         if (m_left == 0) begin
            m_mode = 2; m_period = calc(m_lat); m_since = 0; m_cnt = 0;
         end
      end else begin
         apply = 0;
         if (sync) begin
            m_since = 0; m_cnt = 0; apply = 1;
         end else if (m_since + 1 == m_period) begin
            m_since = 0;
            m_cnt   = (m_cnt + 1) % (SUB * BPMS);
            apply   = (m_cnt % SUB == 0) ? 1 : 0;
         end else begin
            m_since++;
         end
         if (apply != 0 && m_pv != 0) begin
            m_period = m_pend; m_pv = 0;
         end
         if (m_bg != 0) begin
            if (int'(bpm) != m_lat) m_stale = 1;
            m_bg_left--;
            if (m_bg_left == 0) begin
               m_bg = 0;
               if (m_stale != 0) m_restart = 1;
               else begin
                  m_pend = calc(m_lat); m_pv = 1;
               end
               m_stale = 0;
            end
         end else if (m_restart != 0 || int'(bpm) != m_lat) begin
            m_bg = 1; m_bg_left = DW; m_lat = int'(bpm); m_restart = 0;
         end
      end
   endtask

   task automatic compare();
      int r, t, s, bi, p, b;
      r  = (m_mode == 2) ? 1 : 0;
      t  = (r != 0 && m_since == 0) ? 1 : 0;
      s  = (r != 0) ? m_cnt % SUB : 0;
      bi = (r != 0) ? (m_cnt / SUB) % BPMS : 0;
      p  = (r != 0) ? m_period : 0;
      b  = (t != 0 && s == 0) ? 1 : 0;
      chk("running", run, r);
      chk("tick", tick, t);
      chk("beat", beat, b);
      chk("measure", meas, (b != 0 && bi == 0) ? 1 : 0);
      chk("sub_idx", sidx, s);
      chk("beat_idx", bidx, bi);
      chk("period", per, p);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic wait_run(output int n);
      n = 0;
      do begin
         cycle(); n++;
      end while (!run && n < 100);
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      do begin
         cycle(); n++;
      end while (!tick && n < 5000);
      if (!tick) chk("tick_timeout", 0, 1);
   endtask

   int n, total, seen, again, r;

   initial begin
      model_clear();
      again = 0;
      repeat (3) @(negedge clk);
      chk("reset_running", run, 0);
      chk("reset_tick", tick, 0);
      chk("reset_period", per, 0);
      rst = 1'b1;
      repeat (3) cycle();

      // Start at 60 BPM: 1 IDLE edge + 16 divide cycles, then a downbeat
      en = 1'b1; bpm = 8'd60;
      wait_run(n);
      chk("div_latency", n, 17);
      chk("period_60", per, 250);
      chk("first_measure", meas, 1);
      wait_tick(n);
      chk("tick_gap_60", n, 250);
      chk("sub_after_gap", sidx, 1);

      // Tempo change mid-beat takes effect on the next beat
      bpm = 8'd120;
      total = 0;
      repeat (3) begin
         wait_tick(n); total += n;
      end
      chk("old_period_to_beat", total, 750);
      chk("beat_at_apply", beat, 1);
      chk("period_120", per, 125);
      wait_tick(n);
      chk("tick_gap_120", n, 125);

      // 90 superseded by 180 during the background divide
      bpm = 8'd90;
      repeat (5) cycle();
      bpm = 8'd180;
      seen = 0; n = 0;
      do begin
         cycle(); n++;
         if (per == 32'd166) seen = 1;
      end while (per == 32'd125 && n < 3000);
      chk("bpm90_never_applied", seen, 0);
      chk("period_180", per, 83);
      chk("applied_on_beat", beat, 1);

      // Forced downbeat
      wait_tick(n);
      repeat (40) cycle();
      sync = 1'b1;
      cycle();
      sync = 1'b0;
      chk("sync_tick", tick, 1);
      chk("sync_measure", meas, 1);
      chk("sync_sub", sidx, 0);
      chk("sync_beat_idx", bidx, 0);
      wait_tick(n);
      chk("tick_after_sync", n, 83);

      // Stop by bpm=0, then by enable
      bpm = 8'd0;
      cycle();
      chk("stop_bpm_running", run, 0);
      chk("stop_bpm_period", per, 0);
      repeat (20) cycle();
      bpm = 8'd60;
      wait_run(n);
      chk("restart_latency", n, 17);
      chk("restart_measure", meas, 1);
      en = 1'b0;
      cycle();
      chk("stop_en_running", run, 0);
      en = 1'b1;
      wait_run(n);
      chk("reenable_latency", n, 17);

      // Asynchronous reset between edges
      repeat (300) cycle();
      #2 rst = 1'b0;
      #1;
      chk("areset_running", run, 0);
      chk("areset_tick", tick, 0);
      chk("areset_period", per, 0);
      chk("areset_sub", sidx, 0);
      model_clear();
      en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (20) cycle();

      // Clamped period of 1: ticks on consecutive cycles
      en_f = 1'b1; bpm_f = 8'd200;
      n = 0;
      do begin
         cycle(); n++;
      end while (!run_f && n < 50);
      chk("fast_latency", n, 9);
      chk("fast_period", per_f, 1);
      chk("fast_measure0", meas_f, 1);
      for (int k = 1; k <= 4; k++) begin
         cycle();
         chk("fast_tick", tick_f, 1);
         chk("fast_sub", sidx_f, k % 2);
         chk("fast_beat", beat_f, (k % 2 == 0) ? 1 : 0);
         chk("fast_measure", meas_f, (k == 4) ? 1 : 0);
      end
      en_f = 1'b0;
      cycle();
      chk("fast_stop", run_f, 0);

      // Randomized run
      en = 1'b1; bpm = 8'($urandom_range(40, 250));
      for (int i = 0; i < 30000; i++) begin
         r = int'($urandom_range(0, 9999));
         sync = 1'b0;
         if (!en && $urandom_range(0, 7) == 0) en = 1'b1;
         if (bpm == 8'd0 && $urandom_range(0, 7) == 0) bpm = 8'($urandom_range(40, 250));
         if (again > 0) begin
            again--;
            if (again == 0) bpm = 8'($urandom_range(40, 250));
         end
         if (r < 6) begin
            bpm = 8'($urandom_range(40, 250));
            if (r < 3) again = int'($urandom_range(1, 20));
         end else if (r < 10) begin
            sync = 1'b1;
         end else if (r == 10) begin
            en = 1'b0;
         end else if (r == 11) begin
            bpm = 8'd0;
         end
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
